// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller of the 5-stage MIPS core:
// forwarding-mux select codes, divide-sequencer state codes and a small
// helper that turns M/W hit flags into an execute-operand select.
package hazard_ctrl_pkg;

  // Execute-stage ALU operand mux selects
  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from writeback result
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from memory-stage ALU result

  // Divide window sequencer states
  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_e;

  // Memory stage is the youngest producer, so it wins over writeback.
  function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
    logic [1:0] sel;
    if (hit_m) begin
      sel = FWD_MEM;
    end else if (hit_w) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_div_stall_fsm.sv
// Divide stall sequencer: holds F/D/E for exactly DIV_CYCLES cycles per divide.
// The first stalled cycle is the IDLE cycle in which div_start_i is seen; the
// remaining DIV_CYCLES-1 cycles are spent in BUSY, counted down by cnt_q.
// A divide request seen while BUSY is the same held instruction and is ignored.
module div_stall_fsm
  import hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic div_start_i,
  output logic divstall_o
);

  // Number of BUSY cycles that follow the initial IDLE stall cycle.
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  // A one-cycle divide never needs the BUSY state.
  localparam logic             DIV_MULTI = (DIV_CYCLES > 1);

  div_state_e       state_q;
  div_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // State and counter registers with synchronous reset; reset aborts a window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, countdown and stall request.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    divstall_o = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (div_start_i) begin
          divstall_o = 1'b1;
          if (DIV_MULTI) begin
            state_d = DIV_BUSY;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = DIV_IDLE;
            cnt_d   = CNT_ZERO;
          end
        end else begin
          divstall_o = 1'b0;
        end
      end
      DIV_BUSY: begin
        divstall_o = 1'b1;
        // cnt_q counts the BUSY cycles still owed, this one included;
        // the last one (cnt_q==1) decrements to zero and returns to IDLE.
        if (cnt_q <= CNT_ONE) begin
          state_d = DIV_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = DIV_BUSY;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d    = DIV_IDLE;
        cnt_d      = CNT_ZERO;
        divstall_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core.
// Generates forwarding-mux selects for the decode compare and execute ALU
// operands, stall/flush enables for the F/D/E pipeline registers, and holds
// the pipeline for a fixed window on every divide (see div_stall_fsm).
// Optional feature macro: HAZARD_STALL_CNT_EN adds the stall_cnt output, a
// free-running count of cycles with stallF asserted.
// All hazard outputs are combinational (zero latency) and forced low in reset.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rsD,
  input  logic [REG_ADDR_W-1:0] rtD,
  input  logic [REG_ADDR_W-1:0] rsE,
  input  logic [REG_ADDR_W-1:0] rtE,
  input  logic [REG_ADDR_W-1:0] writeregE,
  input  logic [REG_ADDR_W-1:0] writeregM,
  input  logic [REG_ADDR_W-1:0] writeregW,
  input  logic                  regwriteE,
  input  logic                  regwriteM,
  input  logic                  regwriteW,
  input  logic                  memtoregE,
  input  logic                  memtoregM,
  input  logic                  branchD,
  input  logic                  pcsrcD,
  input  logic                  div_startE,
  output logic                  forwardAD,
  output logic                  forwardBD,
  output logic [1:0]            forwardAE,
  output logic [1:0]            forwardBE,
  output logic                  stallF,
  output logic                  stallD,
  output logic                  stallE,
  output logic                  flushD,
  output logic                  flushE,
  output logic                  div_busy
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = REG_ADDR_W'(0);

  // $0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic reg_hit(input logic [REG_ADDR_W-1:0] dst,
                                   input logic [REG_ADDR_W-1:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

  logic       divstall_s;
  logic       lwstall_s;
  logic       brstall_s;
  logic       stall_fd_s;
  logic       hit_e_d_s;   // E destination matches a D source
  logic       hit_m_d_s;   // M destination matches a D source
  logic       fwd_ad_s;
  logic       fwd_bd_s;
  logic [1:0] fwd_ae_s;
  logic [1:0] fwd_be_s;
  logic       flush_d_s;
  logic       flush_e_s;

  div_stall_fsm #(
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_div_fsm (
    .clk         (clk),
    .rst         (rst),
    .div_start_i (div_startE),
    .divstall_o  (divstall_s)
  );

  // Raw forwarding selects and stall/flush terms from the stage fields.
  always_comb begin
    hit_e_d_s  = reg_hit(writeregE, rsD) | reg_hit(writeregE, rtD);
    hit_m_d_s  = reg_hit(writeregM, rsD) | reg_hit(writeregM, rtD);

    fwd_ad_s   = regwriteM & reg_hit(writeregM, rsD);
    fwd_bd_s   = regwriteM & reg_hit(writeregM, rtD);
    fwd_ae_s   = fwd_sel(regwriteM & reg_hit(writeregM, rsE),
                         regwriteW & reg_hit(writeregW, rsE));
    fwd_be_s   = fwd_sel(regwriteM & reg_hit(writeregM, rtE),
                         regwriteW & reg_hit(writeregW, rtE));

    // Load result is not ready for the instruction right behind it.
    lwstall_s  = memtoregE & regwriteE & hit_e_d_s;
    // Branch compares in D: an ALU result still in E, or a load in M, is too late.
    brstall_s  = branchD & ((regwriteE & hit_e_d_s) | (memtoregM & hit_m_d_s));

    stall_fd_s = lwstall_s | brstall_s | divstall_s;
    // A divide holds E in place, so E must not also be turned into a bubble.
    flush_e_s  = (lwstall_s | brstall_s) & ~divstall_s;
    // A taken branch still waiting on its operands must not flush yet.
    flush_d_s  = pcsrcD & ~stall_fd_s;
  end

  // Drive outputs, forced inactive while reset is held.
  always_comb begin
    forwardAD = 1'b0;
    forwardBD = 1'b0;
    forwardAE = FWD_RF;
    forwardBE = FWD_RF;
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    div_busy  = 1'b0;
    if (rst) begin
      forwardAD = 1'b0;
      forwardBD = 1'b0;
      forwardAE = FWD_RF;
      forwardBE = FWD_RF;
      stallF    = 1'b0;
      stallD    = 1'b0;
      stallE    = 1'b0;
      flushD    = 1'b0;
      flushE    = 1'b0;
      div_busy  = 1'b0;
    end else begin
      forwardAD = fwd_ad_s;
      forwardBD = fwd_bd_s;
      forwardAE = fwd_ae_s;
      forwardBE = fwd_be_s;
      stallF    = stall_fd_s;
      stallD    = stall_fd_s;
      stallE    = divstall_s;
      flushD    = flush_d_s;
      flushE    = flush_e_s;
      div_busy  = divstall_s;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Next stall count; wraps naturally at 2**32.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stallF) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall-cycle counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Two instances share all inputs:
// dut_a with DIV_CYCLES=4 and dut_b with DIV_CYCLES=1. A specification-level
// model (divide windows tracked by start cycle number) is compared against
// both DUTs every cycle; directed steps add hand-computed literal checks.
// Honours HAZARD_STALL_CNT_EN when defined.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       fad;
    logic       fbd;
    logic [1:0] fae;
    logic [1:0] fbe;
    logic       sf;
    logic       sd;
    logic       se;
    logic       fd;
    logic       fe;
    logic       busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic       branchD, pcsrcD, div_startE;

  logic       fad_a, fbd_a, sf_a, sd_a, se_a, fd_a, fe_a, busy_a;
  logic [1:0] fae_a, fbe_a;
  logic       fad_b, fbd_b, sf_b, sd_b, se_b, fd_b, fe_b, busy_b;
  logic [1:0] fae_b, fbe_b;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] scnt_a, scnt_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0_a     = -1000000;   // start cycle of the current/last divide window
  int t0_b     = -1000000;
  int mcnt_a   = 0;          // model stall counters
  int mcnt_b   = 0;
  logic exp_sf_a = 1'b0;
  logic exp_sf_b = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_W(5), .DIV_CYCLES(4), .CNT_W(6)) dut_a (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD),
    .pcsrcD(pcsrcD), .div_startE(div_startE),
    .forwardAD(fad_a), .forwardBD(fbd_a), .forwardAE(fae_a), .forwardBE(fbe_a),
    .stallF(sf_a), .stallD(sd_a), .stallE(se_a), .flushD(fd_a), .flushE(fe_a),
    .div_busy(busy_a)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cnt(scnt_a)
`endif
  );

  hazard_ctrl #(.REG_ADDR_W(5), .DIV_CYCLES(1), .CNT_W(6)) dut_b (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD),
    .pcsrcD(pcsrcD), .div_startE(div_startE),
    .forwardAD(fad_b), .forwardBD(fbd_b), .forwardAE(fae_b), .forwardBE(fbe_b),
    .stallF(sf_b), .stallD(sd_b), .stallE(se_b), .flushD(fd_b), .flushE(fe_b),
    .div_busy(busy_b)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cnt(scnt_b)
`endif
  );

  function automatic logic hit(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  function automatic logic in_window(input int now, input int t0, input int dc);
    return (now >= t0) && ((now - t0) < dc);
  endfunction

  // Expected outputs from the hazard rules, given whether a divide stalls now.
  function automatic exp_t model(input logic divst);
    exp_t e;
    logic lw, br, st;
    e  = '0;
    lw = memtoregE & regwriteE & (hit(writeregE, rsD) | hit(writeregE, rtD));
    br = branchD & ((regwriteE & (hit(writeregE, rsD) | hit(writeregE, rtD))) |
                    (memtoregM & (hit(writeregM, rsD) | hit(writeregM, rtD))));
    st = lw | br | divst;
    e.fad  = regwriteM & hit(writeregM, rsD);
    e.fbd  = regwriteM & hit(writeregM, rtD);
    e.fae  = (regwriteM & hit(writeregM, rsE)) ? 2'b10 :
             (regwriteW & hit(writeregW, rsE)) ? 2'b01 : 2'b00;
    e.fbe  = (regwriteM & hit(writeregM, rtE)) ? 2'b10 :
             (regwriteW & hit(writeregW, rtE)) ? 2'b01 : 2'b00;
    e.sf   = st;
    e.sd   = st;
    e.se   = divst;
    e.fd   = pcsrcD & ~st;
    e.fe   = (lw | br) & ~divst;
    e.busy = divst;
    if (rst) e = '0;
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic exp_t pack_a();
    return {fad_a, fbd_a, fae_a, fbe_a, sf_a, sd_a, se_a, fd_a, fe_a, busy_a};
  endfunction
  function automatic exp_t pack_b();
    return {fad_b, fbd_b, fae_b, fbe_b, sf_b, sd_b, se_b, fd_b, fe_b, busy_b};
  endfunction

  // Model bookkeeping at each rising edge: divide window starts and stall counts.
  always @(posedge clk) begin
    if (rst) begin
      t0_a   <= -1000000;
      t0_b   <= -1000000;
      mcnt_a <= 0;
      mcnt_b <= 0;
    end else begin
      if (div_startE && !in_window(cyc, t0_a, 4)) t0_a <= cyc;
      if (div_startE && !in_window(cyc, t0_b, 1)) t0_b <= cyc;
      if (exp_sf_a) mcnt_a <= mcnt_a + 1;
      if (exp_sf_b) mcnt_b <= mcnt_b + 1;
    end
    cyc <= cyc + 1;
  end

  // Every-cycle comparison of both DUTs against the model, mid-cycle.
  always @(negedge clk) begin : compare
    exp_t ea, eb;
    ea = model(in_window(cyc, t0_a, 4) | div_startE);
    eb = model(in_window(cyc, t0_b, 1) | div_startE);
    check("model dut_a outputs", 32'(pack_a()), 32'(ea));
    check("model dut_b outputs", 32'(pack_b()), 32'(eb));
    exp_sf_a <= ea.sf;
    exp_sf_b <= eb.sf;
`ifdef HAZARD_STALL_CNT_EN
    check("model dut_a stall_cnt", scnt_a, 32'(mcnt_a));
    check("model dut_b stall_cnt", scnt_b, 32'(mcnt_b));
`endif
  end

  task automatic clr();
    rsD = 5'd0; rtD = 5'd0; rsE = 5'd0; rtE = 5'd0;
    writeregE = 5'd0; writeregM = 5'd0; writeregW = 5'd0;
    regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
    memtoregE = 1'b0; memtoregM = 1'b0;
    branchD = 1'b0; pcsrcD = 1'b0; div_startE = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    // Reset: everything low
    sample();
    check("reset outputs a", 32'(pack_a()), 32'd0);
    check("reset outputs b", 32'(pack_b()), 32'd0);
    next_cycle();
    rst = 1'b0;

    // Execute forwarding: M beats W, then W, then $0 never forwards
    regwriteM = 1'b1; writeregM = 5'd8; regwriteW = 1'b1; writeregW = 5'd8; rsE = 5'd8;
    sample();
    check("fwdAE M priority", 32'(fae_a), 32'h2);
    next_cycle();
    regwriteM = 1'b0;
    sample();
    check("fwdAE W", 32'(fae_a), 32'h1);
    next_cycle();
    regwriteM = 1'b1; writeregM = 5'd0; writeregW = 5'd0; rsE = 5'd0;
    sample();
    check("fwdAE reg0", 32'(fae_a), 32'h0);
    next_cycle();
    clr(); regwriteW = 1'b1; writeregW = 5'd12; rtE = 5'd12;
    sample();
    check("fwdBE W", 32'(fbe_a), 32'h1);
    next_cycle();

    // Load-use stall: one cycle, bubble into E
    clr(); memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 5'd9; rtD = 5'd9;
    sample();
    check("lw stallF", 32'(sf_a), 32'h1);
    check("lw stallD", 32'(sd_a), 32'h1);
    check("lw flushE", 32'(fe_a), 32'h1);
    check("lw stallE", 32'(se_a), 32'h0);
    next_cycle();
    clr();
    sample();
    check("lw released", 32'(sf_a), 32'h0);
    next_cycle();

    // Load-use on $0 is not a hazard
    memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 5'd0; rsD = 5'd0;
    sample();
    check("lw reg0 no stall", 32'(sf_a), 32'h0);
    next_cycle();

    // Taken branch waiting on an E producer, then forwarded from M
    clr(); branchD = 1'b1; pcsrcD = 1'b1; regwriteE = 1'b1; writeregE = 5'd4; rsD = 5'd4;
    sample();
    check("br stallD", 32'(sd_a), 32'h1);
    check("br flushD held", 32'(fd_a), 32'h0);
    next_cycle();
    regwriteE = 1'b0; writeregE = 5'd0; regwriteM = 1'b1; writeregM = 5'd4;
    sample();
    check("br flushD", 32'(fd_a), 32'h1);
    check("br forwardAD", 32'(fad_a), 32'h1);
    next_cycle();
    // Branch waiting on a load in M
    clr(); branchD = 1'b1; memtoregM = 1'b1; writeregM = 5'd5; rtD = 5'd5;
    sample();
    check("br load-in-M stall", 32'(sf_a), 32'h1);
    next_cycle();

    // Divide held in E for four cycles, concurrent load-use hazard
    clr(); div_startE = 1'b1;
    memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 5'd3; rsD = 5'd3;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("div held busy", 32'(busy_a), 32'h1);
      check("div held stallE", 32'(se_a), 32'h1);
      check("div held flushE", 32'(fe_a), 32'h0);
      next_cycle();
    end
    clr();
    sample();
    check("div held done", 32'(busy_a), 32'h0);
    check("div held no stallF", 32'(sf_a), 32'h0);
    next_cycle();

    // Single-cycle start pulse; restart request during BUSY is ignored
    div_startE = 1'b1;
    sample();
    check("div pulse a c0", 32'(busy_a), 32'h1);
    check("div pulse b c0", 32'(busy_b), 32'h1);
    next_cycle();
    div_startE = 1'b0;
    sample();
    check("div pulse a c1", 32'(busy_a), 32'h1);
    check("div pulse b c1", 32'(busy_b), 32'h0);
    next_cycle();
    div_startE = 1'b1;
    sample();
    check("div pulse a c2", 32'(busy_a), 32'h1);
    next_cycle();
    div_startE = 1'b0;
    sample();
    check("div pulse a c3", 32'(busy_a), 32'h1);
    next_cycle();
    sample();
    check("div pulse a c4", 32'(busy_a), 32'h0);
    next_cycle();

    // Reset on the second BUSY cycle aborts the window
    div_startE = 1'b1;
    next_cycle();
    div_startE = 1'b0;
    next_cycle();
    rst = 1'b1;
    memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 5'd7; rtD = 5'd7; pcsrcD = 1'b1;
    sample();
    check("rst busy outputs a", 32'(pack_a()), 32'd0);
    next_cycle();
    rst = 1'b0;
    clr();
    sample();
    check("after rst busy", 32'(busy_a), 32'h0);
    next_cycle();

`ifdef HAZARD_STALL_CNT_EN
    // 3 load-use cycles + 4-cycle divide = 7 stalled cycles
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 5'd9; rtD = 5'd9;
    repeat (3) next_cycle();
    clr(); div_startE = 1'b1;
    next_cycle();
    div_startE = 1'b0;
    repeat (3) next_cycle();
    sample();
    check("stall_cnt a", scnt_a, 32'd7);
    check("stall_cnt b", scnt_b, 32'd4);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    sample();
    check("stall_cnt rst", scnt_a, 32'd0);
    next_cycle();
    rst = 1'b0;
`endif

    repeat (2) next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
